// File: rtl/la_readout_pkg.sv
// Shared definitions for the logic-analyzer readout block: FSM encoding,
// default frame marker and frame-length helpers.
package la_readout_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEND_HDR,
    SEND_STS,
    RD_ADDR,
    RD_LATCH,
    SEND_WORD,
    SEND_CSUM,
    FINISH
  } state_t;

  localparam logic [7:0] HDR_BYTE_DEFAULT = 8'hA5;
  localparam int         ADDR_W_DEFAULT   = 5;

  // Header + status + four bytes per word + checksum.
  function automatic int frame_len(input int addr_w);
    return 3 + 4 * (1 << addr_w);
  endfunction

  localparam int FRAME_LEN = frame_len(ADDR_W_DEFAULT);

endpackage

// File: rtl/la_readout_if.sv
// Capture-RAM read port plus byte-wide host link with a valid/ready handshake.
interface la_readout_if #(
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] la_ai;
  logic [31:0]       la_dout;
  logic [7:0]        la_status;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (
    output la_ai, tx_data, tx_valid,
    input  la_dout, la_status, tx_ready
  );

  modport slave (
    input  la_ai, tx_data, tx_valid,
    output la_dout, la_status, tx_ready
  );
endinterface

// File: rtl/la_readout.sv
// Streams the capture RAM to the host as one frame:
// header, status, every word MSB first, then an 8-bit running checksum.
module la_readout
  import la_readout_pkg::*;
#(
  parameter int         ADDR_W   = ADDR_W_DEFAULT,
  parameter logic [7:0] HDR_BYTE = HDR_BYTE_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          busy,
  output logic          done,
  la_readout_if.master  bus
);

  localparam logic [ADDR_W-1:0] LAST_IDX = '1;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] la_ai_q, la_ai_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [31:0]       shift_q, shift_d;
  logic [7:0]        csum_q, csum_d;
  logic [7:0]        status_q, status_d;
  logic              xfer;

  assign xfer = bus.tx_valid & bus.tx_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      la_ai_q    <= '0;
      byte_cnt_q <= '0;
      shift_q    <= '0;
      csum_q     <= '0;
      status_q   <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      la_ai_q    <= la_ai_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
      csum_q     <= csum_d;
      status_q   <= status_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (start) state_d = SEND_HDR;
      SEND_HDR:  if (xfer)  state_d = SEND_STS;
      SEND_STS:  if (xfer)  state_d = RD_ADDR;
      RD_ADDR:              state_d = RD_LATCH;
      RD_LATCH:             state_d = SEND_WORD;
      SEND_WORD: if (xfer && byte_cnt_q == 2'd3)
                   state_d = (idx_q == LAST_IDX) ? SEND_CSUM : RD_ADDR;
      SEND_CSUM: if (xfer)  state_d = FINISH;
      FINISH:               state_d = IDLE;
      default:              state_d = IDLE;
    endcase
  end

  // Datapath: serializer, word index, checksum and the frozen status byte.
  always_comb begin
    idx_d      = idx_q;
    la_ai_d    = la_ai_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    csum_d     = csum_q;
    status_d   = status_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          status_d   = bus.la_status;
          csum_d     = '0;
          idx_d      = '0;
          byte_cnt_d = '0;
        end
      end
      SEND_STS: begin
        if (xfer) csum_d = csum_q + status_q;
      end
      RD_ADDR: begin
        la_ai_d = idx_q;
      end
      RD_LATCH: begin
        shift_d    = bus.la_dout;
        byte_cnt_d = '0;
      end
      SEND_WORD: begin
        if (xfer) begin
          csum_d     = csum_q + shift_q[31:24];
          shift_d    = {shift_q[23:0], 8'h00};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3 && idx_q != LAST_IDX) idx_d = idx_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  // The address is presented combinationally in RD_ADDR so data is ready in RD_LATCH.
  always_comb begin
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    bus.la_ai    = (state_q == RD_ADDR) ? idx_q : la_ai_q;
    busy         = (state_q != IDLE);
    done         = (state_q == FINISH);
    case (state_q)
      SEND_HDR: begin
        bus.tx_valid = 1'b1;
        bus.tx_data  = HDR_BYTE;
      end
      SEND_STS: begin
        bus.tx_valid = 1'b1;
        bus.tx_data  = status_q;
      end
      SEND_WORD: begin
        bus.tx_valid = 1'b1;
        bus.tx_data  = shift_q[31:24];
      end
      SEND_CSUM: begin
        bus.tx_valid = 1'b1;
        bus.tx_data  = csum_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_la_readout.sv
// Scoreboard bench for la_readout: expected frames are queued at START and
// a negedge monitor checks every transferred byte, hold stability and LA_AI.
module tb_la_readout;

  localparam int ADDR_W = 5;
  localparam int WORDS  = 1 << ADDR_W;

  logic clk;
  logic rst_n;
  logic start;
  logic busy;
  logic done;

  la_readout_if #(.ADDR_W(ADDR_W)) bus();

  la_readout #(.ADDR_W(ADDR_W), .HDR_BYTE(8'hA5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .busy  (busy),
    .done  (done),
    .bus   (bus)
  );

  logic [31:0] ram [WORDS];
  logic [7:0]  exp_q [$];
  int          check_count = 0;
  int          pass_count  = 0;
  int          done_count  = 0;
  int          frame_pos   = 0;
  int          ready_mode  = 0;
  logic [7:0]  last_byte   = 8'h00;
  logic        prev_hold   = 1'b0;
  logic [7:0]  held_data   = 8'h00;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) bus.la_dout <= ram[bus.la_ai];

  always @(posedge clk) begin
    #1;
    if (ready_mode == 1) bus.tx_ready = ($urandom_range(99) < 30);
    else                 bus.tx_ready = 1'b1;
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_count++;
    if (act === exp) pass_count++;
    else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic fill_ram(input int mode);
    for (int k = 0; k < WORDS; k++) begin
      case (mode)
        0:       ram[k] = 32'h0101_0101 * k;
        1:       ram[k] = 32'h0000_0000;
        default: ram[k] = 32'hFFFF_FFFF;
      endcase
    end
  endtask

  task automatic push_frame(input logic [7:0] status);
    logic [7:0] sum;
    logic [31:0] w;
    exp_q.push_back(8'hA5);
    exp_q.push_back(status);
    sum = status;
    for (int k = 0; k < WORDS; k++) begin
      w = ram[k];
      for (int b = 3; b >= 0; b--) begin
        exp_q.push_back(w[b*8 +: 8]);
        sum = sum + w[b*8 +: 8];
      end
    end
    exp_q.push_back(sum);
  endtask

  task automatic apply_stimulus(input logic [7:0] status);
    bus.la_status = status;
    push_frame(status);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int base;
    int n;
    base = done_count;
    n = 0;
    while (done_count == base && n < budget) begin
      @(posedge clk);
      n++;
    end
    check_output("done_seen", (done_count > base), 1);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
  endtask

  // Monitor: compares transferred bytes, hold stability and the address trace.
  always @(negedge clk) begin
    if (!rst_n) begin
      frame_pos = 0;
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check_output("hold_valid", bus.tx_valid, 1);
        check_output("hold_data", bus.tx_data, held_data);
      end
      if (bus.tx_valid && bus.tx_ready) begin
        if (exp_q.size() == 0) begin
          check_output("unexpected_byte", bus.tx_data, 32'hFFFF_FFFF);
        end else begin
          check_output($sformatf("byte%0d", frame_pos), bus.tx_data, exp_q.pop_front());
        end
        if (frame_pos >= 2 && frame_pos < 2 + 4 * WORDS && ((frame_pos - 2) % 4) == 0)
          check_output($sformatf("la_ai_word%0d", (frame_pos - 2) / 4), bus.la_ai, (frame_pos - 2) / 4);
        last_byte = bus.tx_data;
        frame_pos++;
      end
      prev_hold = bus.tx_valid && !bus.tx_ready;
      held_data = bus.tx_data;
      if (done) begin
        done_count++;
        frame_pos = 0;
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_tx_valid"}, bus.tx_valid, 0);
    check_output({tag, "_tx_data"}, bus.tx_data, 0);
    check_output({tag, "_busy"}, busy, 0);
    check_output({tag, "_done"}, done, 0);
    check_output({tag, "_la_ai"}, bus.la_ai, 0);
  endtask

  task automatic run_frame(input int mode, input logic [7:0] status, input logic [7:0] csum, input string tag);
    int base;
    base = done_count;
    fill_ram(mode);
    apply_stimulus(status);
    check_output({tag, "_busy_high"}, busy, 1);
    wait_done(4000);
    check_output({tag, "_csum"}, last_byte, csum);
    idle_cycles(5);
    check_output({tag, "_done_pulses"}, done_count - base, 1);
    check_output({tag, "_queue_empty"}, exp_q.size(), 0);
    check_output({tag, "_busy_low"}, busy, 0);
  endtask

  initial begin
    int base;
    int n;
    rst_n = 1'b0;
    start = 1'b0;
    bus.la_status = 8'h00;
    bus.tx_ready = 1'b1;
    fill_ram(0);
    idle_cycles(3);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1 rst_n = 1'b1;
    idle_cycles(2);

    run_frame(0, 8'h3C, 8'hFC, "ramp");
    run_frame(1, 8'h00, 8'h00, "zeros");
    run_frame(2, 8'hFF, 8'h7F, "ones");

    ready_mode = 1;
    run_frame(0, 8'h3C, 8'hFC, "throttled");
    ready_mode = 0;
    idle_cycles(2);

    // Extra START mid-frame and in the FINISH cycle must be ignored.
    base = done_count;
    fill_ram(0);
    apply_stimulus(8'h3C);
    idle_cycles(20);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    n = 0;
    @(negedge clk);
    while (!done && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check_output("restart_done_seen", done, 1);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    idle_cycles(300);
    check_output("restart_done_pulses", done_count - base, 1);
    check_output("restart_queue_empty", exp_q.size(), 0);
    check_output("restart_busy_low", busy, 0);

    // Reset partway through a frame aborts it without DONE.
    base = done_count;
    fill_ram(0);
    apply_stimulus(8'h3C);
    n = 0;
    while (frame_pos < 50 && n < 4000) begin
      @(posedge clk);
      n++;
    end
    check_output("midreset_reached", (frame_pos >= 50), 1);
    #1 rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    exp_q.delete();
    idle_cycles(2);
    #1 rst_n = 1'b1;
    idle_cycles(10);
    check_output("midreset_no_done", done_count - base, 0);
    check_output("midreset_idle", busy, 0);
    run_frame(0, 8'h3C, 8'hFC, "after_reset");

    $display("[TB] %0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
